cfr_cpw_loader: RTL and testbench
=================================

// Module: cfr_cpw_loader
// PURPOSE
//  Control-side initiator for the per-branch CPW (cancellation pulse waveform) RAM ports of the CFR.
//  Takes one full CPW table (I/Q beats) on an AXI-Stream. Writes it to every branch selected by a mask (LOAD).
//  VERIFY mode reads the same branches back and compares them against a streamed reference.
//  Sits between the control DMA/register bank and the ctrl_pc_cfr_cpw_* ports of the CFR top.
// PARAMETERS
//  NUM_BRANCH      16  number of CFR branches driven
//  CPW_ADDR_WIDTH  8   CPW RAM address width; table depth DEPTH = 2**CPW_ADDR_WIDTH
//  CPW_DATA_WIDTH  16  width of each I and Q coefficient
//  CPW_RD_LATENCY  2   cycles from en&!we to valid rd_data at the CFR branch (>=1)
// PORTS
//  ctrl_clk         in   1                 single clock for the whole block
//  ctrl_rst         in   1                 synchronous, active-high reset
//  cmd_start        in   1                 1-cycle pulse; accepted only when !busy
//  cmd_verify       in   1                 sampled with cmd_start: 0=LOAD, 1=VERIFY
//  cmd_branch_mask  in   NUM_BRANCH        branches targeted; sampled with cmd_start
//  s_axis_tdata     in   2*CPW_DATA_WIDTH  {Q,I}; I in the low half
//  s_axis_tvalid    in   1                 AXIS valid
//  s_axis_tready    out  1                 AXIS ready
//  s_axis_tlast     in   1                 marks beat DEPTH-1
//  cpw_addr         out  CPW_ADDR_WIDTH    [NUM_BRANCH] unpacked; same value on all branches
//  cpw_en           out  1                 [NUM_BRANCH]; asserted only for masked branches
//  cpw_we           out  1                 [NUM_BRANCH]
//  cpw_wr_data_i/q  out  CPW_DATA_WIDTH    [NUM_BRANCH]
//  cpw_rd_data_i/q  in   CPW_DATA_WIDTH    [NUM_BRANCH]
//  busy             out  1                 command in progress
//  done             out  1                 1-cycle pulse at command end
//  err_length       out  1                 sticky until next cmd_start: tlast misplaced
//  mismatch         out  NUM_BRANCH        sticky per branch until next cmd_start: VERIFY compare failed
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, address counter 0. The mask register, cpw_addr and wr_data also reset to 0.
//  FSM states:
//   - IDLE -> RUN on cmd_start.
//     At that transition: latch mode and mask; clear err_length and mismatch; addr=0.
//   - RUN -> DRAIN on the accepted beat DEPTH-1, or on an early tlast.
//   - DRAIN waits CPW_RD_LATENCY+1 cycles (VERIFY) or 1 cycle (LOAD), then -> IDLE with done=1.
//  cmd_start while busy: ignored, no state change.
//  s_axis_tready = (state==RUN). One beat is accepted per cycle on tvalid&tready.
//  Accepted beat:
//   - Drive addr and data for one cycle, registered: output appears the cycle after the handshake.
//   - cpw_en[b] = mask[b]; cpw_we[b] = mask[b] & !verify.
//   - Then addr++.
//   - tvalid low: cpw_en=0 that cycle (bubble); addr holds.
//  VERIFY compare:
//   - Expected {Q,I} and an address-valid bit travel through a CPW_RD_LATENCY-deep delay line.
//   - When the delayed valid is set, for each masked b: rd_data_i/q != expected -> mismatch[b] set.
//   - Unmasked branches are never compared.
//  Length rules (counter width CPW_ADDR_WIDTH+1, no wrap inside a command):
//   - tlast on a beat with addr<DEPTH-1: that beat is written/compared, err_length=1, -> DRAIN.
//   - No tlast on beat DEPTH-1: beat is used, err_length=1, -> DRAIN.
//   - Further stream beats are left un-accepted (tready=0) for upstream to flush.
//  Empty mask: the command runs normally and consumes the stream, but no cpw_en is ever asserted.
//  ctrl_rst mid-command: immediate return to IDLE, outputs as reset. No done pulse; the partial RAM content stays as is.
//  done and cmd_start in the same cycle: the new command is accepted (busy drops only for that cycle).
// STRUCTURE
//  Shared package cfr_pkg:
//   - typedef cpw_sample_t = struct packed {q,i}
//   - enum cpw_loader_state_t {IDLE,RUN,DRAIN}
//   - localparam CPW_DEPTH function of CPW_ADDR_WIDTH
//  Sub-module cfr_cpw_cmp_pipe: the delay line plus the per-branch comparator and sticky flags.
//  The top holds the FSM, the AXIS handshake and the output registers.
// TESTING (NUM_BRANCH=16, ADDR_W=8, DATA_W=16, RD_LATENCY=2)
//  1. LOAD mask=16'h0005, beats I=addr, Q=~addr, tlast at beat 255.
//     -> RAM models 0,2 hold the pattern, others untouched; 256 we pulses per branch; done once; err_length=0.
//  2. VERIFY mask=16'h0005 after test 1, same stream -> mismatch=0, done.
//     Repeat with beat 17 I flipped -> mismatch=16'h0005.
//  3. LOAD with tvalid toggling randomly 50%.
//     -> addresses contiguous 0..255; no en during bubbles; result as in test 1.
//  4. tlast at beat 99 -> beats 0..99 written, err_length=1, tready=0 afterwards, done pulses.
//     No tlast at 255 -> err_length=1 also.
//  5. cmd_start during RUN ignored. ctrl_rst at beat 50 -> busy=0, no done, outputs 0.
//     A new cmd_start then behaves as in test 1.
//  6. VERIFY with mask=0 -> 256 beats consumed, no cpw_en, mismatch=0, done.

Source files
------------

// File: rtl/cfr_pkg.sv
// Shared CFR types and constants: CPW sample layout, CPW loader FSM states and table depth.
package cfr_pkg;

    localparam int CPW_ADDR_W_DFLT = 8;
    localparam int CPW_DATA_W_DFLT = 16;

    typedef struct packed {
        logic [CPW_DATA_W_DFLT-1:0] q;
        logic [CPW_DATA_W_DFLT-1:0] i;
    } cpw_sample_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } cpw_loader_state_t;

    function automatic int cpw_depth(input int addr_width);
        return 2 ** addr_width;
    endfunction

    localparam int CPW_DEPTH = cpw_depth(CPW_ADDR_W_DFLT);

endpackage

// File: rtl/cfr_cpw_cmp_pipe.sv
// VERIFY read-back checker: delays the expected {Q,I} beat to line up with branch read data
// and keeps a sticky per-branch mismatch flag.
module cfr_cpw_cmp_pipe
    import cfr_pkg::*;
#(
    parameter int NUM_BRANCH     = 16,
    parameter int CPW_DATA_WIDTH = 16,
    parameter int CPW_RD_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        vld_in,
    input  logic [2*CPW_DATA_WIDTH-1:0] exp_in,
    input  logic [NUM_BRANCH-1:0]       mask,
    input  logic [CPW_DATA_WIDTH-1:0]   rd_data_i [NUM_BRANCH],
    input  logic [CPW_DATA_WIDTH-1:0]   rd_data_q [NUM_BRANCH],
    output logic [NUM_BRANCH-1:0]       mismatch
);

    logic [CPW_RD_LATENCY-1:0]   vld_dl_r;
    logic [2*CPW_DATA_WIDTH-1:0] exp_dl_r [CPW_RD_LATENCY];
    logic [NUM_BRANCH-1:0]       diff_s;
    logic [NUM_BRANCH-1:0]       mismatch_r;

    // Delay line: expected beat and its valid bit, CPW_RD_LATENCY stages deep.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_dl_r <= {CPW_RD_LATENCY{1'b0}};
            for (int s = 0; s < CPW_RD_LATENCY; s++) begin
                exp_dl_r[s] <= {(2*CPW_DATA_WIDTH){1'b0}};
            end
        end else begin
            vld_dl_r[0] <= vld_in;
            exp_dl_r[0] <= exp_in;
            for (int s = 1; s < CPW_RD_LATENCY; s++) begin
                vld_dl_r[s] <= vld_dl_r[s-1];
                exp_dl_r[s] <= exp_dl_r[s-1];
            end
        end
    end

    // Per-branch compare, only for masked branches while a delayed beat is valid.
    always_comb begin
        diff_s = {NUM_BRANCH{1'b0}};
        for (int b = 0; b < NUM_BRANCH; b++) begin
            if (mask[b] && vld_dl_r[CPW_RD_LATENCY-1]) begin
                diff_s[b] = ({rd_data_q[b], rd_data_i[b]} != exp_dl_r[CPW_RD_LATENCY-1]);
            end else begin
                diff_s[b] = 1'b0;
            end
        end
    end

    // Sticky mismatch flags, cleared when a new command is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_r <= {NUM_BRANCH{1'b0}};
        end else if (clr) begin
            mismatch_r <= {NUM_BRANCH{1'b0}};
        end else begin
            mismatch_r <= mismatch_r | diff_s;
        end
    end

    assign mismatch = mismatch_r;

endmodule

// File: rtl/cfr_cpw_loader.sv
// CPW table loader/verifier: streams one AXIS CPW table into the RAM port of every masked
// CFR branch (LOAD) or reads those branches back and compares against the stream (VERIFY).
module cfr_cpw_loader
    import cfr_pkg::*;
#(
    parameter int NUM_BRANCH     = 16,
    parameter int CPW_ADDR_WIDTH = 8,
    parameter int CPW_DATA_WIDTH = 16,
    parameter int CPW_RD_LATENCY = 2
) (
    input  logic                        ctrl_clk,
    input  logic                        ctrl_rst,
    input  logic                        cmd_start,
    input  logic                        cmd_verify,
    input  logic [NUM_BRANCH-1:0]       cmd_branch_mask,
    input  logic [2*CPW_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [CPW_ADDR_WIDTH-1:0]   cpw_addr      [NUM_BRANCH],
    output logic                        cpw_en        [NUM_BRANCH],
    output logic                        cpw_we        [NUM_BRANCH],
    output logic [CPW_DATA_WIDTH-1:0]   cpw_wr_data_i [NUM_BRANCH],
    output logic [CPW_DATA_WIDTH-1:0]   cpw_wr_data_q [NUM_BRANCH],
    input  logic [CPW_DATA_WIDTH-1:0]   cpw_rd_data_i [NUM_BRANCH],
    input  logic [CPW_DATA_WIDTH-1:0]   cpw_rd_data_q [NUM_BRANCH],
    output logic                        busy,
    output logic                        done,
    output logic                        err_length,
    output logic [NUM_BRANCH-1:0]       mismatch
);

    localparam int CNT_W = CPW_ADDR_WIDTH + 1;
    localparam int DRN_W = $clog2(CPW_RD_LATENCY + 2);
    localparam logic [CNT_W-1:0] LAST_ADDR    = CNT_W'(cpw_depth(CPW_ADDR_WIDTH) - 1);
    localparam logic [DRN_W-1:0] DRAIN_VERIFY = DRN_W'(CPW_RD_LATENCY);
    localparam logic [DRN_W-1:0] DRAIN_LOAD   = {DRN_W{1'b0}};

    cpw_loader_state_t           state_r, state_s;
    logic [CNT_W-1:0]            cnt_r;
    logic [DRN_W-1:0]            drain_r;
    logic                        verify_r;
    logic [NUM_BRANCH-1:0]       mask_r;
    logic                        busy_r, tready_r, done_r, err_r;
    logic [CPW_ADDR_WIDTH-1:0]   addr_r;
    logic [2*CPW_DATA_WIDTH-1:0] wdata_r;
    logic [NUM_BRANCH-1:0]       en_r, we_r;
    logic                        rd_vld_r;
    logic                        start_s, accept_s, at_last_s, last_beat_s, drain_end_s;

    assign start_s     = cmd_start && (state_r == IDLE);
    assign accept_s    = s_axis_tvalid && (state_r == RUN);
    assign at_last_s   = (cnt_r == LAST_ADDR);
    assign last_beat_s = accept_s && (s_axis_tlast || at_last_s);
    assign drain_end_s = (state_r == DRAIN) &&
                         (drain_r == (verify_r ? DRAIN_VERIFY : DRAIN_LOAD));

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (cmd_start)   state_s = RUN;   else state_s = IDLE;
            RUN:     if (last_beat_s) state_s = DRAIN; else state_s = RUN;
            DRAIN:   if (drain_end_s) state_s = IDLE;  else state_s = DRAIN;
            default: state_s = IDLE;
        endcase
    end

    // Control registers: state, command latch, beat counter, drain timer and status flags.
    always_ff @(posedge ctrl_clk) begin
        if (ctrl_rst) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            tready_r <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            verify_r <= 1'b0;
            mask_r   <= {NUM_BRANCH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            drain_r  <= {DRN_W{1'b0}};
        end else begin
            state_r  <= state_s;
            busy_r   <= (state_s != IDLE);
            tready_r <= (state_s == RUN);
            done_r   <= drain_end_s;
            if (start_s) begin
                verify_r <= cmd_verify;
                mask_r   <= cmd_branch_mask;
                cnt_r    <= {CNT_W{1'b0}};
                err_r    <= 1'b0;
            end else if (accept_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
                // tlast must coincide exactly with the final table entry
                if (s_axis_tlast != at_last_s) begin
                    err_r <= 1'b1;
                end
            end
            if (state_r == DRAIN) begin
                drain_r <= drain_r + DRN_W'(1);
            end else begin
                drain_r <= {DRN_W{1'b0}};
            end
        end
    end

    // RAM port registers: one enable pulse per accepted beat, address/data hold through bubbles.
    always_ff @(posedge ctrl_clk) begin
        if (ctrl_rst) begin
            addr_r   <= {CPW_ADDR_WIDTH{1'b0}};
            wdata_r  <= {(2*CPW_DATA_WIDTH){1'b0}};
            en_r     <= {NUM_BRANCH{1'b0}};
            we_r     <= {NUM_BRANCH{1'b0}};
            rd_vld_r <= 1'b0;
        end else if (accept_s) begin
            addr_r   <= cnt_r[CPW_ADDR_WIDTH-1:0];
            wdata_r  <= s_axis_tdata;
            en_r     <= mask_r;
            we_r     <= mask_r & {NUM_BRANCH{~verify_r}};
            rd_vld_r <= verify_r;
        end else begin
            en_r     <= {NUM_BRANCH{1'b0}};
            we_r     <= {NUM_BRANCH{1'b0}};
            rd_vld_r <= 1'b0;
        end
    end

    for (genvar b = 0; b < NUM_BRANCH; b++) begin : g_port
        assign cpw_addr[b]      = addr_r;
        assign cpw_en[b]        = en_r[b];
        assign cpw_we[b]        = we_r[b];
        assign cpw_wr_data_i[b] = wdata_r[CPW_DATA_WIDTH-1:0];
        assign cpw_wr_data_q[b] = wdata_r[2*CPW_DATA_WIDTH-1:CPW_DATA_WIDTH];
    end

    cfr_cpw_cmp_pipe #(
        .NUM_BRANCH     (NUM_BRANCH),
        .CPW_DATA_WIDTH (CPW_DATA_WIDTH),
        .CPW_RD_LATENCY (CPW_RD_LATENCY)
    ) u_cmp_pipe (
        .clk       (ctrl_clk),
        .rst       (ctrl_rst),
        .clr       (start_s),
        .vld_in    (rd_vld_r),
        .exp_in    (wdata_r),
        .mask      (mask_r),
        .rd_data_i (cpw_rd_data_i),
        .rd_data_q (cpw_rd_data_q),
        .mismatch  (mismatch)
    );

    assign s_axis_tready = tready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err_length    = err_r;

endmodule

// File: tb/tb_cfr_cpw_loader.sv
// Randomized bench for cfr_cpw_loader: per-branch CPW RAM models with 2-cycle read latency,
// and a table-level reference of expected RAM contents, pulse counts and status flags.
module tb_cfr_cpw_loader;
    import cfr_pkg::*;

    localparam int NB = 16;
    localparam int DEPTH = 256;

    logic        clk, rst, ram_init;
    logic        cmd_start, cmd_verify;
    logic [15:0] cmd_branch_mask;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [7:0]  cpw_addr      [NB];
    logic        cpw_en        [NB];
    logic        cpw_we        [NB];
    logic [15:0] cpw_wr_data_i [NB];
    logic [15:0] cpw_wr_data_q [NB];
    logic [15:0] cpw_rd_data_i [NB];
    logic [15:0] cpw_rd_data_q [NB];
    logic        busy, done, err_length;
    logic [15:0] mismatch;

    logic [31:0] ram_m   [NB][DEPTH];
    logic [31:0] exp_ram [NB][DEPTH];
    logic [31:0] rd1 [NB];
    logic [31:0] rd2 [NB];

    int checks = 0;
    int failures = 0;
    int en_cnt [NB];
    int we_cnt [NB];
    int done_cnt = 0;
    int addr_err = 0;
    int mon_next = 0;

    cfr_cpw_loader #(
        .NUM_BRANCH(NB), .CPW_ADDR_WIDTH(8), .CPW_DATA_WIDTH(16), .CPW_RD_LATENCY(2)
    ) dut (
        .ctrl_clk        (clk),
        .ctrl_rst        (rst),
        .cmd_start       (cmd_start),
        .cmd_verify      (cmd_verify),
        .cmd_branch_mask (cmd_branch_mask),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .cpw_addr        (cpw_addr),
        .cpw_en          (cpw_en),
        .cpw_we          (cpw_we),
        .cpw_wr_data_i   (cpw_wr_data_i),
        .cpw_wr_data_q   (cpw_wr_data_q),
        .cpw_rd_data_i   (cpw_rd_data_i),
        .cpw_rd_data_q   (cpw_rd_data_q),
        .busy            (busy),
        .done            (done),
        .err_length      (err_length),
        .mismatch        (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int b, input int a);
        return {16'hC3C3, 8'(b), 8'(a)};
    endfunction

    function automatic logic [31:0] beat_word(input int a, input logic [15:0] salt, input int flip);
        cpw_sample_t w;
        w.i = 16'(a) ^ salt;
        w.q = ~(16'(a)) ^ salt;
        if (a == flip) w.i = ~w.i;
        return w;
    endfunction

    function automatic bit any_en();
        bit r = 1'b0;
        for (int b = 0; b < NB; b++) r |= cpw_en[b];
        return r;
    endfunction

    function automatic bit addr_ok(input int expv);
        bit r = 1'b1;
        for (int b = 0; b < NB; b++) if (cpw_addr[b] != 8'(expv)) r = 1'b0;
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Branch RAM models: synchronous write, 2-cycle registered read.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (ram_init) begin
                for (int a = 0; a < DEPTH; a++) ram_m[b][a] <= init_word(b, a);
                rd1[b] <= 32'h0;
                rd2[b] <= 32'h0;
            end else begin
                if (cpw_en[b] && cpw_we[b]) ram_m[b][cpw_addr[b]] <= {cpw_wr_data_q[b], cpw_wr_data_i[b]};
                if (cpw_en[b] && !cpw_we[b]) rd1[b] <= ram_m[b][cpw_addr[b]];
                rd2[b] <= rd1[b];
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            cpw_rd_data_i[b] = rd2[b][15:0];
            cpw_rd_data_q[b] = rd2[b][31:16];
        end
    end

    // Port monitor: pulse counts and address contiguity per command.
    always @(negedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (cpw_en[b]) en_cnt[b] <= en_cnt[b] + 1;
            if (cpw_en[b] && cpw_we[b]) we_cnt[b] <= we_cnt[b] + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (rst || (cmd_start && !busy)) begin
            mon_next <= 0;
        end else if (any_en()) begin
            if (!addr_ok(mon_next)) addr_err <= addr_err + 1;
            mon_next <= mon_next + 1;
        end
    end

    task automatic run_cmd(input string name, input bit vfy, input logic [15:0] msk, input int last_at,
                           input logic [15:0] salt, input int flip, input int bubble,
                           input int start_at, input int rst_at);
        logic [31:0] beats [DEPTH];
        int n_exp, beat, cyc, done0, aerr0;
        int en0 [NB];
        int we0 [NB];
        logic [15:0] en_ok, we_ok, ram_ok, mm_exp;
        bit hs, aborted, pulsed;
        n_exp = (last_at >= 0 && last_at < DEPTH - 1) ? last_at + 1 : DEPTH;
        for (int a = 0; a < DEPTH; a++) beats[a] = beat_word(a, salt, flip);
        for (int b = 0; b < NB; b++) begin en0[b] = en_cnt[b]; we0[b] = we_cnt[b]; end
        done0 = done_cnt;
        aerr0 = addr_err;

        cmd_start = 1'b1; cmd_verify = vfy; cmd_branch_mask = msk;
        @(posedge clk); #1;
        cmd_start = 1'b0; cmd_verify = 1'b0; cmd_branch_mask = 16'h0;

        beat = 0; cyc = 0; aborted = 1'b0; pulsed = 1'b0;
        while (beat < n_exp && cyc < 3000 && !aborted) begin
            if (beat == rst_at) begin
                s_axis_tvalid = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                aborted = 1'b1;
            end else begin
                if (beat == start_at && !pulsed) begin
                    cmd_start = 1'b1; cmd_verify = 1'b1; cmd_branch_mask = 16'hFFFF;
                    pulsed = 1'b1;
                end
                s_axis_tvalid = ($urandom_range(99) >= bubble);
                s_axis_tdata  = beats[beat];
                s_axis_tlast  = (beat == last_at);
                @(negedge clk);
                hs = s_axis_tvalid && s_axis_tready;
                @(posedge clk); #1;
                cmd_start = 1'b0; cmd_verify = 1'b0; cmd_branch_mask = 16'h0;
                if (hs) beat++;
                cyc++;
            end
        end

        if (aborted) begin
            @(negedge clk);
            check_eq({name, "_rst_busy"}, 64'(busy), 64'd0);
            check_eq({name, "_rst_tready"}, 64'(s_axis_tready), 64'd0);
            check_eq({name, "_rst_en"}, 64'(any_en()), 64'd0);
            check_eq({name, "_rst_addr"}, 64'(cpw_addr[0]), 64'd0);
            check_eq({name, "_rst_wdata"}, 64'({cpw_wr_data_q[3], cpw_wr_data_i[3]}), 64'd0);
            check_eq({name, "_rst_flags"}, 64'({err_length, mismatch}), 64'd0);
            repeat (6) @(posedge clk);
            @(negedge clk); #1;
            check_eq({name, "_rst_no_done"}, 64'(done_cnt - done0), 64'd0);
        end else begin
            check_eq({name, "_beats"}, 64'(beat), 64'(n_exp));
            s_axis_tvalid = 1'b1; s_axis_tdata = 32'hFFFF_FFFF; s_axis_tlast = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check_eq({name, "_tready_after"}, 64'(s_axis_tready), 64'd0);
                @(posedge clk); #1;
            end
            s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
            repeat (6) @(posedge clk);
            @(negedge clk); #1;
            mm_exp = 16'h0;
            if (vfy) begin
                for (int b = 0; b < NB; b++)
                    for (int a = 0; a < n_exp; a++)
                        if (msk[b] && beats[a] != exp_ram[b][a]) mm_exp[b] = 1'b1;
            end
            check_eq({name, "_done_once"}, 64'(done_cnt - done0), 64'd1);
            check_eq({name, "_busy_end"}, 64'(busy), 64'd0);
            check_eq({name, "_err_length"}, 64'(err_length), 64'(last_at != DEPTH - 1));
            check_eq({name, "_mismatch"}, 64'(mismatch), 64'(mm_exp));
            check_eq({name, "_addr_seq"}, 64'(addr_err - aerr0), 64'd0);
        end

        // table-level expectation: beats 0..beat-1 reach every masked branch
        for (int b = 0; b < NB; b++) begin
            en_ok[b] = ((en_cnt[b] - en0[b]) == (msk[b] ? beat : 0));
            we_ok[b] = ((we_cnt[b] - we0[b]) == ((msk[b] && !vfy) ? beat : 0));
            if (msk[b] && !vfy)
                for (int a = 0; a < beat; a++) exp_ram[b][a] = beats[a];
            ram_ok[b] = 1'b1;
            for (int a = 0; a < DEPTH; a++) if (ram_m[b][a] !== exp_ram[b][a]) ram_ok[b] = 1'b0;
        end
        check_eq({name, "_en_count"}, 64'(en_ok), 64'hFFFF);
        check_eq({name, "_we_count"}, 64'(we_ok), 64'hFFFF);
        check_eq({name, "_ram"}, 64'(ram_ok), 64'hFFFF);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] salt3, m3b, m4;
        rst = 1'b1; ram_init = 1'b1;
        cmd_start = 1'b0; cmd_verify = 1'b0; cmd_branch_mask = 16'h0;
        s_axis_tdata = 32'h0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        for (int b = 0; b < NB; b++) begin
            en_cnt[b] = 0; we_cnt[b] = 0;
            for (int a = 0; a < DEPTH; a++) exp_ram[b][a] = init_word(b, a);
        end
        repeat (3) @(posedge clk); #1;
        ram_init = 1'b0;
        @(negedge clk);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_tready", 64'(s_axis_tready), 64'd0);
        check_eq("reset_flags", 64'({err_length, mismatch}), 64'd0);
        check_eq("reset_en", 64'(any_en()), 64'd0);
        check_eq("reset_addr", 64'(cpw_addr[5]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        salt3 = 16'($urandom);
        m3b   = 16'($urandom) | 16'h0005;
        m4    = 16'($urandom);
        run_cmd("t1_load",        1'b0, 16'h0005, 255, 16'h0,  -1,  0, -1, -1);
        run_cmd("t2_verify",      1'b1, 16'h0005, 255, 16'h0,  -1,  0, -1, -1);
        run_cmd("t2_verify_flip", 1'b1, 16'h0005, 255, 16'h0,  17,  0, -1, -1);
        run_cmd("t3_load_bubble", 1'b0, 16'h0005, 255, salt3,  -1, 50, -1, -1);
        run_cmd("t3_verify_rand", 1'b1, m3b,      255, salt3,  -1, 30, -1, -1);
        run_cmd("t4_early_tlast", 1'b0, m4,        99, 16'h1234, -1, 20, -1, -1);
        run_cmd("t4_no_tlast",    1'b0, 16'h0005,  -1, 16'h00FF, -1, 0, -1, -1);
        run_cmd("t5_start_busy",  1'b0, 16'h0005, 255, 16'hA5A5, -1, 10, 30, -1);
        run_cmd("t5_rst_mid",     1'b0, 16'h0030, 255, 16'h5A5A, -1, 0, -1, 50);
        run_cmd("t5_after_rst",   1'b0, 16'h0005, 255, 16'h0,  -1,  0, -1, -1);
        run_cmd("t6_verify_mask0", 1'b1, 16'h0000, 255, 16'h0, -1, 25, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
